// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap entry / xRET exit sequencer.
package trap_sequencer_pkg;

  localparam int unsigned XLEN_DEF    = 64;
  localparam int unsigned CAUSE_W_DEF = 6;

  // Privilege encodings
  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  // tvec MODE field encodings
  localparam logic [1:0] MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MODE_VECTORED = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_REDIRECT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    KIND_TRAP = 2'd0,
    KIND_MRET = 2'd1,
    KIND_SRET = 2'd2
  } kind_e;

endpackage

// File: rtl/trap_target_calc.sv
// Combinational delegation decision and redirect-target selection.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets.
module trap_target_calc
  import trap_sequencer_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned CAUSE_W = CAUSE_W_DEF
) (
  input  logic               req_is_int,
  input  logic [CAUSE_W-1:0] req_code,
  input  logic [1:0]         priv_mode,
  input  logic [XLEN-1:0]    medeleg,
  input  logic [XLEN-1:0]    mideleg,
  input  logic [1:0]         lat_kind,
  input  logic               lat_is_int,
  input  logic [CAUSE_W-1:0] lat_code,
  input  logic               lat_to_s,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    stvec,
  input  logic [XLEN-1:0]    mepc,
  input  logic [XLEN-1:0]    sepc,
  output logic               deleg_s_c,
  output logic [XLEN-1:0]    target_pc_c
);

  logic [XLEN-1:0] deleg;
  logic [XLEN-1:0] tvec;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] trap_pc;

  // Delegation to S only from below M and when the matching deleg bit is set
  always_comb begin
    deleg     = req_is_int ? mideleg : medeleg;
    deleg_s_c = (priv_mode != PRIV_M) && deleg[req_code];
  end

`ifdef TRAP_VECTORED_EN
  // Vectored mode only offsets interrupts; reserved modes behave as direct
  always_comb begin
    tvec = lat_to_s ? stvec : mtvec;
    base = {tvec[XLEN-1:2], 2'b00};
    if (lat_is_int && (tvec[1:0] == MODE_VECTORED)) begin
      trap_pc = base + (XLEN'(lat_code) << 2);
    end else begin
      trap_pc = base;
    end
  end
`else
  // Mode bits ignored: every trap lands on the base address
  always_comb begin
    tvec    = lat_to_s ? stvec : mtvec;
    base    = {tvec[XLEN-1:2], 2'b00};
    trap_pc = base;
  end

  logic unused_mode_bits;
  assign unused_mode_bits = ^{tvec[1:0], lat_is_int, lat_code};
`endif

  // Final target: trap handler or saved return address
  always_comb begin
    target_pc_c = trap_pc;
    if (lat_kind == KIND_MRET) begin
      target_pc_c = mepc;
    end else if (lat_kind == KIND_SRET) begin
      target_pc_c = sepc;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / xRET exit sequencer: accept, flush, drain, commit CSR
// updates, then redirect fetch. Optional macro TRAP_VECTORED_EN
// (handled in trap_target_calc) enables vectored interrupt targets.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned CAUSE_W = CAUSE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_valid,
  input  logic               exc_is_int,
  input  logic [CAUSE_W-1:0] exc_code,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic               mret_req,
  input  logic               sret_req,
  input  logic [1:0]         priv_mode,
  input  logic [XLEN-1:0]    medeleg,
  input  logic [XLEN-1:0]    mideleg,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    stvec,
  input  logic [XLEN-1:0]    mepc,
  input  logic [XLEN-1:0]    sepc,
  input  logic               pipe_idle,
  input  logic               redir_ready,
  output logic               req_accept,
  output logic               busy,
  output logic               flush,
  output logic               trap_target_m,
  output logic               trap_target_s,
  output logic               csr_trap_wr,
  output logic               csr_ret_m,
  output logic               csr_ret_s,
  output logic [XLEN-1:0]    cause_out,
  output logic [XLEN-1:0]    epc_out,
  output logic [XLEN-1:0]    tval_out,
  output logic               redir_valid,
  output logic [XLEN-1:0]    redir_pc
);

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic               is_int_q, is_int_d;
  logic [CAUSE_W-1:0] code_q, code_d;
  logic               to_s_q, to_s_d;

  logic               req_accept_d, busy_d, flush_d;
  logic               tgt_m_d, tgt_s_d;
  logic               csr_trap_wr_d, csr_ret_m_d, csr_ret_s_d;
  logic               redir_valid_d;
  logic [XLEN-1:0]    cause_d, epc_d, tval_d, redir_pc_d;

  logic               deleg_s_c;
  logic [XLEN-1:0]    target_pc_c;

  trap_target_calc #(
    .XLEN    (XLEN),
    .CAUSE_W (CAUSE_W)
  ) u_calc (
    .req_is_int  (exc_is_int),
    .req_code    (exc_code),
    .priv_mode   (priv_mode),
    .medeleg     (medeleg),
    .mideleg     (mideleg),
    .lat_kind    (kind_q),
    .lat_is_int  (is_int_q),
    .lat_code    (code_q),
    .lat_to_s    (to_s_q),
    .mtvec       (mtvec),
    .stvec       (stvec),
    .mepc        (mepc),
    .sepc        (sepc),
    .deleg_s_c   (deleg_s_c),
    .target_pc_c (target_pc_c)
  );

  // Next-state and next-output decode
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    is_int_d      = is_int_q;
    code_d        = code_q;
    to_s_d        = to_s_q;
    req_accept_d  = 1'b0;
    flush_d       = 1'b0;
    tgt_m_d       = 1'b0;
    tgt_s_d       = 1'b0;
    csr_trap_wr_d = 1'b0;
    csr_ret_m_d   = 1'b0;
    csr_ret_s_d   = 1'b0;
    redir_valid_d = 1'b0;
    cause_d       = cause_out;
    epc_d         = epc_out;
    tval_d        = tval_out;
    redir_pc_d    = redir_pc;

    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          kind_d       = KIND_TRAP;
          is_int_d     = exc_is_int;
          code_d       = exc_code;
          to_s_d       = deleg_s_c;
          cause_d      = {exc_is_int, (XLEN-1)'(exc_code)};
          epc_d        = exc_pc;
          tval_d       = exc_tval;
          req_accept_d = 1'b1;
          state_d      = ST_FLUSH;
        end else if (mret_req) begin
          kind_d       = KIND_MRET;
          to_s_d       = 1'b0;
          req_accept_d = 1'b1;
          state_d      = ST_FLUSH;
        end else if (sret_req) begin
          kind_d       = KIND_SRET;
          to_s_d       = 1'b0;
          req_accept_d = 1'b1;
          state_d      = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush_d = 1'b1;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipe_idle) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        csr_trap_wr_d = (kind_q == KIND_TRAP);
        csr_ret_m_d   = (kind_q == KIND_MRET);
        csr_ret_s_d   = (kind_q == KIND_SRET);
        tgt_m_d       = (kind_q == KIND_TRAP) && !to_s_q;
        tgt_s_d       = (kind_q == KIND_TRAP) && to_s_q;
        redir_pc_d    = target_pc_c;
        state_d       = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redir_valid && redir_ready) begin
          state_d = ST_IDLE;
        end else begin
          redir_valid_d = 1'b1;
          tgt_m_d       = trap_target_m;
          tgt_s_d       = trap_target_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, latched request fields and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      kind_q        <= KIND_TRAP;
      is_int_q      <= 1'b0;
      code_q        <= '0;
      to_s_q        <= 1'b0;
      req_accept    <= 1'b0;
      busy          <= 1'b0;
      flush         <= 1'b0;
      trap_target_m <= 1'b0;
      trap_target_s <= 1'b0;
      csr_trap_wr   <= 1'b0;
      csr_ret_m     <= 1'b0;
      csr_ret_s     <= 1'b0;
      cause_out     <= '0;
      epc_out       <= '0;
      tval_out      <= '0;
      redir_valid   <= 1'b0;
      redir_pc      <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      is_int_q      <= is_int_d;
      code_q        <= code_d;
      to_s_q        <= to_s_d;
      req_accept    <= req_accept_d;
      busy          <= busy_d;
      flush         <= flush_d;
      trap_target_m <= tgt_m_d;
      trap_target_s <= tgt_s_d;
      csr_trap_wr   <= csr_trap_wr_d;
      csr_ret_m     <= csr_ret_m_d;
      csr_ret_s     <= csr_ret_s_d;
      cause_out     <= cause_d;
      epc_out       <= epc_d;
      tval_out      <= tval_d;
      redir_valid   <= redir_valid_d;
      redir_pc      <= redir_pc_d;
    end
  end

endmodule
